// File: rtl/serial_frame_receiver_if.sv
// Serial-in / parallel-out bundle for serial_frame_receiver.
// The master modport is the receiver; the slave modport is the pin driver plus word consumer.
interface serial_frame_receiver_if #(
  parameter int WIDTH = 8
);
  logic             SI;
  logic             Shift;
  logic             Ack;
  logic [WIDTH-1:0] PO;
  logic             Valid;
  logic             FrameErr;
  logic             Overrun;
  logic             Busy;

  modport master (
    input  SI, Shift, Ack,
    output PO, Valid, FrameErr, Overrun, Busy
  );

  modport slave (
    output SI, Shift, Ack,
    input  PO, Valid, FrameErr, Overrun, Busy
  );
endinterface

// File: rtl/serial_frame_receiver.sv
// LSB-first serial frame receiver: start(0), WIDTH data bits, stop(1), sampled on Shift strobes.
// A correctly framed word is presented on PO under a Valid/Ack handshake.
module serial_frame_receiver #(
  parameter int WIDTH = 8
) (
  input  logic                    C,
  input  logic                    Reset_n,
  serial_frame_receiver_if.master bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_po;
  logic             r_valid;
  logic             r_ferr;
  logic             r_ovr;
  logic             r_busy;

  wire w_ack = bus.Ack & r_valid;

  always_ff @(posedge C or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_po    <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      if (w_ack) begin
        r_valid <= 1'b0;
        r_ovr   <= 1'b0;
      end
      if (bus.Shift) begin
        case (r_state)
          IDLE: begin
            if (!bus.SI) begin
              r_state <= DATA;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end
          end
          DATA: begin
            r_sr  <= {bus.SI, r_sr[WIDTH-1:1]};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH - 1)) r_state <= STOP;
          end
          STOP: begin
            if (bus.SI) begin
              r_po    <= r_sr;
              r_valid <= 1'b1;
              r_ferr  <= 1'b0;
              // A same-edge Ack consumes the old word, so the overwrite is not an overrun.
              r_ovr   <= r_valid & ~bus.Ack;
            end else begin
              r_ferr  <= 1'b1;
            end
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.PO       = r_po;
  assign bus.Valid    = r_valid;
  assign bus.FrameErr = r_ferr;
  assign bus.Overrun  = r_ovr;
  assign bus.Busy     = r_busy;
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: framing, handshake, overrun, break and async reset.
module tb_serial_frame_receiver;
  localparam int WIDTH = 8;

  logic C = 1'b0;
  logic Reset_n;
  int   n_chk = 0;
  int   n_err = 0;

  serial_frame_receiver_if #(.WIDTH(WIDTH)) bus();

  serial_frame_receiver #(.WIDTH(WIDTH)) dut (
    .C       (C),
    .Reset_n (Reset_n),
    .bus     (bus.master)
  );

  always #5 C = ~C;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One strobe: driven at a falling edge, sampled by the next rising edge, settled by the next falling edge.
  task automatic strobe(input logic si);
    @(negedge C);
    bus.SI = si; bus.Shift = 1'b1;
    @(negedge C);
    bus.Shift = 1'b0; bus.SI = 1'b1;
  endtask

  task automatic gap(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge C);
      bus.SI = 1'($urandom_range(0, 1));
    end
    bus.SI = 1'b1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic stop, input int g);
    strobe(1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      gap(g);
      strobe(d[i]);
    end
    gap(g);
    strobe(stop);
  endtask

  task automatic ack();
    @(negedge C);
    bus.Ack = 1'b1;
    @(negedge C);
    bus.Ack = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] po, input logic v,
                         input logic fe, input logic ov, input logic bz);
    chk({tag, ".PO"},       32'(bus.PO),       32'(po));
    chk({tag, ".Valid"},    32'(bus.Valid),    32'(v));
    chk({tag, ".FrameErr"}, 32'(bus.FrameErr), 32'(fe));
    chk({tag, ".Overrun"},  32'(bus.Overrun),  32'(ov));
    chk({tag, ".Busy"},     32'(bus.Busy),     32'(bz));
  endtask

  initial begin
    logic [7:0] d;
    bus.SI = 1'b1; bus.Shift = 1'b0; bus.Ack = 1'b0;
    Reset_n = 1'b0;
    #12;
    chk_out("reset", 8'h00, 0, 0, 0, 0);
    Reset_n = 1'b1;

    for (int i = 0; i < 20; i++) strobe(1'b1);
    chk_out("idle", 8'h00, 0, 0, 0, 0);

    // 0xA5: SI per strobe 0,1,0,1,0,0,1,0,1,1
    strobe(1'b0);
    chk("a5.busy_after_start", 32'(bus.Busy), 32'd1);
    d = 8'hA5;
    for (int i = 0; i < WIDTH; i++) strobe(d[i]);
    chk("a5.valid_before_stop", 32'(bus.Valid), 32'd0);
    chk("a5.busy_before_stop", 32'(bus.Busy), 32'd1);
    strobe(1'b1);
    chk_out("a5.done", 8'hA5, 1, 0, 0, 0);
    ack();
    chk_out("a5.acked", 8'hA5, 0, 0, 0, 0);

    send(8'h3C, 1'b1, 3);
    chk_out("3c.gapped", 8'h3C, 1, 0, 0, 0);
    ack();

    send(8'h81, 1'b0, 0);
    chk_out("81.badstop", 8'h3C, 0, 1, 0, 0);
    ack();
    chk("81.ack_keeps_ferr", 32'(bus.FrameErr), 32'd1);
    send(8'h42, 1'b1, 0);
    chk_out("42.good", 8'h42, 1, 0, 0, 0);
    ack();

    send(8'h11, 1'b1, 0);
    chk_out("11.unacked", 8'h11, 1, 0, 0, 0);
    send(8'h22, 1'b1, 0);
    chk_out("22.overrun", 8'h22, 1, 0, 1, 0);
    ack();
    chk_out("22.ack_clears", 8'h22, 0, 0, 0, 0);

    send(8'h11, 1'b1, 0);
    strobe(1'b0);
    d = 8'h22;
    for (int i = 0; i < WIDTH; i++) strobe(d[i]);
    @(negedge C);
    bus.SI = 1'b1; bus.Shift = 1'b1; bus.Ack = 1'b1;
    @(negedge C);
    bus.Shift = 1'b0; bus.Ack = 1'b0;
    chk_out("22.simul_ack", 8'h22, 1, 0, 0, 0);
    ack();

    // Break: all-zero frame with a zero stop; the next zero is a fresh start bit.
    send(8'h00, 1'b0, 0);
    chk_out("brk.badstop", 8'h22, 0, 1, 0, 0);
    strobe(1'b0);
    chk("brk.restart_busy", 32'(bus.Busy), 32'd1);
    d = 8'h99;
    for (int i = 0; i < WIDTH; i++) strobe(d[i]);
    strobe(1'b1);
    chk_out("brk.99", 8'h99, 1, 0, 0, 0);

    // Asynchronous reset after data bit 4 of 0xFF.
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    #3 Reset_n = 1'b0;
    #1 chk_out("midrst.async", 8'h00, 0, 0, 0, 0);
    #9 Reset_n = 1'b1;
    send(8'h5A, 1'b1, 0);
    chk_out("5a.after_rst", 8'h5A, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
